tile_row_sequencer: RTL

Backtracking scheduler for one row of LEN tile instances. It passes a single turn token along the chain and moves the pointer forward on passfwd and backward on passbak. It also drives the shared occupiedmask and rowbias buses seen by the active tile. It sits between the top-level generator FSM and a row of tiles, and reports done, fail and a backtrack count upward.

---
 rtl/tile_pkg.sv | 28 ++
 rtl/bias_lfsr.sv | 17 +
 rtl/tile_row_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/tile_pkg.sv
// Shared types and helpers for the tile row sequencer and its bias generator.
`ifndef GRID_LEN
`define GRID_LEN 4
`endif

package tile_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, DONE, FAIL} state_t;

  // Galois taps for x^16+x^14+x^13+x^11+1, right-shifting form
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam int MAX_LEN = 16;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0000);
  endfunction

  // OR of the one-hot values of tiles below ptr; only the low len bits are meaningful
  function automatic logic [MAX_LEN-1:0] or_below(input logic [MAX_LEN*MAX_LEN-1:0] v,
                                                  input int len, input int ptr);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int j = 0; j < MAX_LEN; j++)
      if (j < ptr) m = m | v[j*len +: MAX_LEN];
    return m;
  endfunction

endpackage

// File: rtl/bias_lfsr.sv
// Free-standing 16-bit Galois LFSR that advances only when stepped.
module bias_lfsr
  import tile_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        step,
  output logic [15:0] out
);

  always_ff @(posedge clock or negedge reset)
    if (!reset)    out <= SEED;
    else if (step) out <= lfsr_next(out);

endmodule

// File: rtl/tile_row_sequencer.sv
// Backtracking turn-token scheduler for one row of tiles, with shared mask and bias buses.
module tile_row_sequencer
  import tile_pkg::*;
#(
  parameter int          LEN     = `GRID_LEN,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          TIMEOUT = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  output logic [LEN-1:0]     myturn,
  input  logic [LEN-1:0]     passfwd,
  input  logic [LEN-1:0]     passbak,
  input  logic [LEN-1:0]     updaterowbias,
  input  logic [LEN*LEN-1:0] value,
  output logic [LEN-1:0]     occupiedmask,
  output logic [LEN-1:0]     rowbias,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [15:0]        backtracks
);

  localparam int PW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0]  WD_LAST  = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [PW-1:0]  PTR_LAST = PW'(LEN - 1);
  localparam logic [LEN-1:0] RB_RESET = (SEED[LEN-1:0] == '0) ? LEN'(1) : SEED[LEN-1:0];

  state_t              state, state_n;
  logic [PW-1:0]       ptr, ptr_n;
  logic [LEN-1:0]      turn_n, mask_n, bias_n;
  logic [15:0]         bt_n, lfsr, lfsr_adv;
  logic [WW-1:0]       wdog, wdog_n;
  logic [MAX_LEN-1:0]  below;
  logic [MAX_LEN*MAX_LEN-1:0] vext;
  logic                step, fwd, bak;

  assign vext = (MAX_LEN*MAX_LEN)'(value);
  assign fwd  = passfwd[ptr];
  assign bak  = passbak[ptr];
  assign step = (state == WAIT) && updaterowbias[ptr];

  bias_lfsr #(.SEED(SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .step  (step),
    .out   (lfsr)
  );

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    turn_n   = '0;
    mask_n   = occupiedmask;
    bt_n     = backtracks;
    wdog_n   = wdog;
    below    = or_below(vext, LEN, int'(ptr));
    lfsr_adv = lfsr_next(lfsr);
    bias_n   = (lfsr_adv[LEN-1:0] == '0) ? LEN'(1) : lfsr_adv[LEN-1:0];
    case (state)
      IDLE, DONE, FAIL:
        if (start) begin
          state_n = SETUP;
          ptr_n   = '0;
          bt_n    = '0;
        end
      SETUP: begin
        mask_n  = below[LEN-1:0];
        turn_n  = LEN'(1) << ptr;   // registered, so it is visible during ISSUE only
        state_n = ISSUE;
      end
      ISSUE: begin
        wdog_n  = '0;
        state_n = WAIT;
      end
      WAIT:
        if (bak) begin
          if (ptr == '0) state_n = FAIL;
          else begin
            ptr_n   = ptr - PW'(1);
            bt_n    = (backtracks == 16'hFFFF) ? backtracks : backtracks + 16'd1;
            state_n = SETUP;
          end
        end else if (fwd) begin
          if (ptr == PTR_LAST) state_n = DONE;
          else begin
            ptr_n   = ptr + PW'(1);
            state_n = SETUP;
          end
        end else begin
          wdog_n = wdog + WW'(1);
          if (TIMEOUT != 0 && wdog == WD_LAST) state_n = FAIL;
        end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state        <= IDLE;
      ptr          <= '0;
      myturn       <= '0;
      occupiedmask <= '0;
      backtracks   <= '0;
      wdog         <= '0;
      rowbias      <= RB_RESET;
      busy         <= 1'b0;
      done         <= 1'b0;
      fail         <= 1'b0;
    end else begin
      state        <= state_n;
      ptr          <= ptr_n;
      myturn       <= turn_n;
      occupiedmask <= mask_n;
      backtracks   <= bt_n;
      wdog         <= wdog_n;
      if (step) rowbias <= bias_n;
      busy         <= (state_n == SETUP) || (state_n == ISSUE) || (state_n == WAIT);
      done         <= (state_n == DONE);
      fail         <= (state_n == FAIL);
    end

endmodule
